chain_score_pipe: RTL and testbench
===================================

Name: chain_score_pipe

Overview:
Parametrised, handshaked successor of the chaining-score datapath. It takes one anchor pair per cycle: anchor i (ri_x, qi_x) and predecessor j (ri_y, qi_y). It computes score = min(dr, dq, w) − (gap·gap_coef + ilog2(gap)/2) in integer/fixed-point arithmetic, with no float units. It sits between the anchor-pair scheduler and the chain DP max-reduction, and adds legality checking and valid/ready backpressure.

Parameters:
DATA_W, 32, width of coordinates, w and internal differences
COEF_W, 16, width of gap_coef, unsigned fixed point
FRAC_W, 8, fractional bits of gap_coef (gap_coef = W_avg·0.01·2^FRAC_W, computed by software)
SCORE_W, 32, signed output score width (SCORE_W ≥ DATA_W)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input pair valid
in_ready  out  1  block accepts the pair this cycle
ri_x, ri_y, qi_x, qi_y  in  DATA_W each  reference/query positions, unsigned
w  in  DATA_W  max span clamp
gap_coef  in  COEF_W  linear gap cost coefficient, Q(COEF_W−FRAC_W).FRAC_W
band  in  DATA_W  max legal gap; port exists only with CHAIN_SCORE_BAND_EN
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_score  out  SCORE_W  signed score
out_ok  out  1  pair is legal (score meaningful)

Behaviour:
- Reset (asynchronous): all stage valid bits = 0 and all data registers = 0. Outputs: out_valid=0, out_score=0, out_ok=0. in_ready=1 after reset.
- Fixed 5-stage pipeline, latency 5 cycles from accepted input to out_valid. Throughput 1 pair/cycle.
- Global enable en = !out_valid || out_ready; in_ready = en. When en=0, every stage register holds its value, including the valid bits.
- A transfer occurs on in_valid && in_ready. A stage with valid=0 carries don't-care data, but its valid bit still shifts.
- S1: dr = ri_x − ri_y, dq = qi_x − qi_y. ok = (ri_x > ri_y) && (qi_x > qi_y).
- S2: gap = |dr − dq| (compute both subtractions, select by compare). mn = min(dr, dq).
- S3: A = min(mn, w). prod = gap · gap_coef, full DATA_W+COEF_W bits. lg = ilog2(gap) >> 1. Define ilog2(0) = 0.
- S4: lin = prod >> FRAC_W, truncated toward zero. B = (gap == 0) ? 0 : lin + lg. B saturates at 2^(SCORE_W−1)−1.
- S5: score = A − B, computed at SCORE_W+1 bits and saturated to [−2^(SCORE_W−1), 2^(SCORE_W−1)−1]. If !ok, out_score = −2^(SCORE_W−1) (NEG_INF) and out_ok = 0.
- ok travels with its data through every stage. An illegal pair still occupies a slot and still produces an output; it is never dropped.
- Output order equals input order. Under any out_ready pattern there is no loss and no duplication.
- Equal coordinates (dr = 0 or dq = 0) are illegal.
- w = 0 gives A = 0.

Optional Feature:
CHAIN_SCORE_BAND_EN
- Defined: the band port exists. At S2, ok &= (gap ≤ band). The gap > band case yields out_ok=0 and NEG_INF.
- Undefined: the band port is absent and there is no band check. All other behaviour is identical, including latency.

Decomposition:
- Package chain_score_pkg holds:
  - default widths
  - the NEG_INF constant function of SCORE_W
  - the saturating-subtract function
- Sub-module ilog2_prio: parametrised combinational priority encoder. Output is floor(log2(v)) for v > 0 and 0 for v = 0. It is instantiated at S3 on gap.

Test Plan:
- Nominal: ri=(1000,900), qi=(560,500), w=5000, gap_coef=64 (0.25) -> dr=100, dq=60, gap=40, A=60, B=10+2=12; out_score=48, out_ok=1, exactly 5 cycles after acceptance.
- Zero gap: ri=(150,100), qi=(80,30), w=30 -> A=30, B=0, out_score=30, out_ok=1.
- Illegal: ri=(900,1000), any qi -> out_ok=0, out_score=0x80000000. A following legal pair is unaffected.
- Backpressure: stream 8 pairs back-to-back and hold out_ready=0 for cycles 6–9 -> in_ready=0 during the stall, the held output is stable, and all 8 results emerge in order with none lost or duplicated.
- Reset mid-stream: assert reset with 3 pairs in flight -> out_valid=0 immediately, out_score=0, and no stale results after reset release.
- Band (macro on): band=32 with the nominal pair (gap=40) -> out_ok=0, NEG_INF. With band=40 -> out_score=48, out_ok=1.

Source files
------------

// File: rtl/chain_score_pkg.sv
// Shared widths and arithmetic helpers for the chaining-score pipeline.
//   - default widths for coordinates, gap coefficient and score
//   - neg_inf(w):        most negative w-bit two's complement value
//   - sat_sub(a, b, w):  a - b on non-negative operands, clamped to the w-bit signed range
// Helpers work on SAT_W-bit containers; callers cast the result down to their width,
// so any width up to SAT_W-1 bits is supported.
package chain_score_pkg;

   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned COEF_W_DEF  = 16;
   localparam int unsigned FRAC_W_DEF  = 8;
   localparam int unsigned SCORE_W_DEF = 32;
   localparam int unsigned SAT_W       = 64;

   // Bit (w-1) set, all others clear: the w-bit NEG_INF pattern in the low bits.
   function automatic logic [SAT_W-1:0] neg_inf(input int unsigned w);
      return SAT_W'(1) << (w - 1);
   endfunction

   // Signed difference of two unsigned operands, saturated to [-2^(w-1), 2^(w-1)-1].
   function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input int unsigned      w);
      logic        [SAT_W:0] lim;
      logic signed [SAT_W:0] d;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      lim = (SAT_W+1)'(1) << (w - 1);
      hi  = $signed(lim - (SAT_W+1)'(1));
      lo  = -$signed(lim);
      d   = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d > hi)      return SAT_W'(hi);
      else if (d < lo) return SAT_W'(lo);
      else             return SAT_W'(d);
   endfunction

endpackage

// File: rtl/chain_score_pipe_if.sv
// Handshake bus of the chaining-score pipeline.
//   input side : in_valid/in_ready, ri_x, ri_y, qi_x, qi_y, w, gap_coef (+ band)
//   output side: out_valid/out_ready, out_score, out_ok
// band exists only when CHAIN_SCORE_BAND_EN is defined.
// Modports: slave = the pipeline, master = the scheduler/consumer driving it.
interface chain_score_pipe_if
   import chain_score_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned COEF_W  = COEF_W_DEF,
   parameter int unsigned SCORE_W = SCORE_W_DEF
);
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   ri_x;
   logic [DATA_W-1:0]   ri_y;
   logic [DATA_W-1:0]   qi_x;
   logic [DATA_W-1:0]   qi_y;
   logic [DATA_W-1:0]   w;
   logic [COEF_W-1:0]   gap_coef;
`ifdef CHAIN_SCORE_BAND_EN
   logic [DATA_W-1:0]   band;
`endif
   logic                out_valid;
   logic                out_ready;
   logic [SCORE_W-1:0]  out_score;
   logic                out_ok;

   modport slave (
`ifdef CHAIN_SCORE_BAND_EN
      input  band,
`endif
      input  in_valid, ri_x, ri_y, qi_x, qi_y, w, gap_coef, out_ready,
      output in_ready, out_valid, out_score, out_ok
   );

   modport master (
`ifdef CHAIN_SCORE_BAND_EN
      output band,
`endif
      output in_valid, ri_x, ri_y, qi_x, qi_y, w, gap_coef, out_ready,
      input  in_ready, out_valid, out_score, out_ok
   );
endinterface

// File: rtl/ilog2_prio.sv
// Combinational priority encoder: o_log_c = floor(log2(i_v)), 0 when i_v == 0.
//   i_v     : W-bit unsigned value
//   o_log_c : index of the highest set bit
module ilog2_prio #(
   parameter  int unsigned W  = 32,
   localparam int unsigned LW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  i_v,
   output logic [LW-1:0] o_log_c
);
   // Ascending scan: the last hit is the most significant set bit.
   always_comb begin
      o_log_c = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (i_v[i]) o_log_c = LW'(i);
      end
   end
endmodule

// File: rtl/chain_score_pipe.sv
// Chaining-score pipeline: score = min(dr, dq, w) - (gap*gap_coef + ilog2(gap)/2).
// Five register stages, one pair per cycle, valid/ready with a single global enable.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : chain_score_pipe_if.slave (input pair handshake, result handshake)
// Optional build macro CHAIN_SCORE_BAND_EN adds the band port and the gap <= band check.
// Illegal pairs keep their slot and come out with out_ok=0 and out_score=NEG_INF.
module chain_score_pipe
   import chain_score_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned COEF_W  = COEF_W_DEF,
   parameter int unsigned FRAC_W  = FRAC_W_DEF,
   parameter int unsigned SCORE_W = SCORE_W_DEF
) (
   input logic              clk,
   input logic              reset,
   chain_score_pipe_if.slave bus
);
   localparam int unsigned PW = DATA_W + COEF_W;
   localparam int unsigned LW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned BW = (PW + 1 > SCORE_W) ? PW + 1 : SCORE_W;
   localparam logic [BW-1:0] B_MAX = (BW'(1) << (SCORE_W - 1)) - BW'(1);

   // Stage registers
   logic               r1_v, r2_v, r3_v, r4_v, r5_v;
   logic               r1_ok, r2_ok, r3_ok, r4_ok, r5_ok;
   logic [DATA_W-1:0]  r1_dr, r1_dq, r1_w;
   logic [COEF_W-1:0]  r1_coef, r2_coef;
`ifdef CHAIN_SCORE_BAND_EN
   logic [DATA_W-1:0]  r1_band;
`endif
   logic [DATA_W-1:0]  r2_gap, r2_mn, r2_w;
   logic [DATA_W-1:0]  r3_a;
   logic [PW-1:0]      r3_prod;
   logic [LW-1:0]      r3_lg;
   logic               r3_gap_nz;
   logic [DATA_W-1:0]  r4_a;
   logic [SCORE_W-1:0] r4_b;
   logic [SCORE_W-1:0] r5_score;

   // Datapath wires
   logic               w_en;
   logic [DATA_W-1:0]  w_dr, w_dq;
   logic               w_ok1;
   logic [DATA_W-1:0]  w_d_rq, w_d_qr, w_gap, w_mn;
   logic               w_rge, w_ok2;
   logic [DATA_W-1:0]  w_a;
   logic [PW-1:0]      w_prod;
   logic [LW-1:0]      w_log;
   logic [PW-1:0]      w_lin;
   logic [BW-1:0]      w_bsum, w_b;
   logic [SCORE_W-1:0] w_score;

   // Any output slot that is empty or being drained lets the whole pipe advance.
   assign w_en         = !r5_v || bus.out_ready;
   assign bus.in_ready = w_en;

   // S1: raw differences and ordering check
   assign w_dr  = bus.ri_x - bus.ri_y;
   assign w_dq  = bus.qi_x - bus.qi_y;
   assign w_ok1 = (bus.ri_x > bus.ri_y) && (bus.qi_x > bus.qi_y);

   // S2: |dr - dq| from both subtractions, selected by the compare
   assign w_rge  = r1_dr >= r1_dq;
   assign w_d_rq = r1_dr - r1_dq;
   assign w_d_qr = r1_dq - r1_dr;
   assign w_gap  = w_rge ? w_d_rq : w_d_qr;
   assign w_mn   = w_rge ? r1_dq  : r1_dr;
`ifdef CHAIN_SCORE_BAND_EN
   assign w_ok2  = r1_ok && (w_gap <= r1_band);
`else
   assign w_ok2  = r1_ok;
`endif

   // S3: span clamp, linear gap product, log term
   assign w_a    = (r2_mn < r2_w) ? r2_mn : r2_w;
   assign w_prod = PW'(r2_gap) * PW'(r2_coef);

   ilog2_prio #(.W(DATA_W)) u_ilog2 (
      .i_v     (r2_gap),
      .o_log_c (w_log)
   );

   // S4: drop the fraction, add the log term, clamp to the positive score range
   assign w_lin  = r3_prod >> FRAC_W;
   assign w_bsum = BW'(w_lin) + BW'(r3_lg);
   assign w_b    = !r3_gap_nz        ? '0    :
                   (w_bsum > B_MAX) ? B_MAX : w_bsum;

   // S5: saturating score, NEG_INF for illegal pairs
   assign w_score = r4_ok ? SCORE_W'(sat_sub(SAT_W'(r4_a), SAT_W'(r4_b), SCORE_W))
                          : SCORE_W'(neg_inf(SCORE_W));

   // Pipeline registers: everything advances or everything holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r1_v <= 1'b0; r2_v <= 1'b0; r3_v <= 1'b0; r4_v <= 1'b0; r5_v <= 1'b0;
         r1_ok <= 1'b0; r2_ok <= 1'b0; r3_ok <= 1'b0; r4_ok <= 1'b0; r5_ok <= 1'b0;
         r1_dr <= '0; r1_dq <= '0; r1_w <= '0; r1_coef <= '0;
`ifdef CHAIN_SCORE_BAND_EN
         r1_band <= '0;
`endif
         r2_gap <= '0; r2_mn <= '0; r2_w <= '0; r2_coef <= '0;
         r3_a <= '0; r3_prod <= '0; r3_lg <= '0; r3_gap_nz <= 1'b0;
         r4_a <= '0; r4_b <= '0;
         r5_score <= '0;
      end else if (w_en) begin
         r1_v    <= bus.in_valid;
         r1_ok   <= w_ok1;
         r1_dr   <= w_dr;
         r1_dq   <= w_dq;
         r1_w    <= bus.w;
         r1_coef <= bus.gap_coef;
`ifdef CHAIN_SCORE_BAND_EN
         r1_band <= bus.band;
`endif
         r2_v    <= r1_v;
         r2_ok   <= w_ok2;
         r2_gap  <= w_gap;
         r2_mn   <= w_mn;
         r2_w    <= r1_w;
         r2_coef <= r1_coef;

         r3_v      <= r2_v;
         r3_ok     <= r2_ok;
         r3_a      <= w_a;
         r3_prod   <= w_prod;
         r3_lg     <= w_log >> 1;
         r3_gap_nz <= (r2_gap != '0);

         r4_v  <= r3_v;
         r4_ok <= r3_ok;
         r4_a  <= r3_a;
         r4_b  <= SCORE_W'(w_b);

         r5_v     <= r4_v;
         r5_ok    <= r4_ok;
         r5_score <= w_score;
      end
   end

   assign bus.out_valid = r5_v;
   assign bus.out_score = r5_score;
   assign bus.out_ok    = r5_ok;

endmodule

// File: tb/tb_chain_score_pipe.sv
// Scoreboard bench for chain_score_pipe: the driver pushes hand-computed expected
// results as pairs are accepted; a monitor pops and compares on each output transfer
// and checks that a stalled output holds the expected value.
module tb_chain_score_pipe;
   import chain_score_pkg::*;

   typedef struct {
      logic [31:0] rx, ry, qx, qy, w, band;
      logic [15:0] coef;
      logic [31:0] score;
      logic        ok;
   } vec_t;

   typedef struct {
      logic [31:0] score;
      logic        ok;
      longint      t_acc;
      bit          chk_lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_push = 0;
   int   n_out  = 0;
   exp_t exp_q[$];

   chain_score_pipe_if bus ();

   chain_score_pipe dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] rx, ry, qx, qy, w,
                               input logic [15:0] coef, input logic [31:0] band,
                               input logic [31:0] score, input logic ok);
      vec_t v;
      v.rx = rx; v.ry = ry; v.qx = qx; v.qy = qy; v.w = w;
      v.coef = coef; v.band = band; v.score = score; v.ok = ok;
      return v;
   endfunction

   // Present one pair and hold it until accepted; the expectation is queued on acceptance.
   task automatic send(input vec_t v, input bit chk_lat);
      bit   rdy;
      bit   done = 0;
      int   guard = 0;
      exp_t e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ri_x = v.rx; bus.ri_y = v.ry; bus.qi_x = v.qx; bus.qi_y = v.qy;
      bus.w = v.w; bus.gap_coef = v.coef;
`ifdef CHAIN_SCORE_BAND_EN
      bus.band = v.band;
`endif
      while (!done) begin
         #1 rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) begin
            e.score = v.score; e.ok = v.ok; e.t_acc = longint'($time); e.chk_lat = chk_lat;
            exp_q.push_back(e);
            n_push++;
            done = 1;
         end else begin
            guard++;
            if (guard > 200) begin
               n_chk++; n_fail++;
               $display("FAIL send_timeout: in_ready low for %0d cycles", guard);
               done = 1;
            end else begin
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int c = 0;
      while (exp_q.size() != 0 && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (exp_q.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: compare on transfer, check hold value while stalled
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!reset && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_output: score %0h ok %0b with nothing expected",
                     bus.out_score, bus.out_ok);
         end else if (bus.out_ready) begin
            e = exp_q.pop_front();
            n_out++;
            chk("out_score", 64'(bus.out_score), 64'(e.score));
            chk("out_ok", 64'(bus.out_ok), 64'(e.ok));
            if (e.chk_lat) chk("latency_time", 64'(longint'($time) - e.t_acc), 64'd47);
         end else begin
            chk("held_score", 64'(bus.out_score), 64'(exp_q[0].score));
         end
      end
   end

   initial begin
      vec_t dir[$];
      vec_t bp[$];
      vec_t nom;
      int   seen;

      reset = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.ri_x = '0; bus.ri_y = '0; bus.qi_x = '0; bus.qi_y = '0;
      bus.w = '0; bus.gap_coef = '0;
`ifdef CHAIN_SCORE_BAND_EN
      bus.band = '1;
`endif
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_score", 64'(bus.out_score), 64'd0);
      chk("rst_out_ok",    64'(bus.out_ok),    64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      nom = mk(1000, 900, 560, 500, 5000, 64, 32'hFFFF_FFFF, 32'd48, 1'b1);

      // Nominal pair alone, with latency check
      send(nom, 1'b1);
      idle();
      drain();

      // Directed vectors, back to back
      dir.push_back(mk(150, 100, 80, 30, 30, 64, 32'hFFFF_FFFF, 32'd30, 1'b1));         // zero gap
      dir.push_back(mk(900, 1000, 560, 500, 5000, 64, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0)); // illegal
      dir.push_back(nom);                                                               // legal after illegal
      dir.push_back(mk(1000, 900, 560, 500, 0, 64, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b1));  // w = 0
      dir.push_back(mk(500, 500, 560, 500, 5000, 64, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0));  // dr = 0
      dir.push_back(mk(1000, 900, 500, 500, 5000, 64, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0)); // dq = 0
      dir.push_back(mk(1060, 1000, 700, 600, 5000, 256, 32'hFFFF_FFFF, 32'd18, 1'b1));     // dq > dr, coef 1.0
      dir.push_back(mk(1000, 0, 2, 1, 5000, 64, 32'hFFFF_FFFF, 32'hFFFF_FF04, 1'b1));      // big gap
      dir.push_back(mk(32'hFFFF_FFFF, 0, 1, 0, 32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF,
                       32'h8000_0002, 1'b1));                                           // B saturates
      dir.push_back(mk(32'hFFFF_FFFF, 15, 32'hFFFF_FFFF, 15, 32'hFFFF_FFFF, 64, 32'hFFFF_FFFF,
                       32'h7FFF_FFFF, 1'b1));                                           // score saturates
      foreach (dir[i]) send(dir[i], 1'b0);
      idle();
      drain();

      // Backpressure: 8 pairs streamed, out_ready low for cycles 6..9
      for (int k = 0; k < 8; k++)
         bp.push_back(mk(1000, 900, 560, 500, 32'(10 + k), 64, 32'hFFFF_FFFF,
                         32'(10 + k) - 32'd12, 1'b1));
      fork
         begin
            foreach (bp[i]) send(bp[i], 1'b0);
            idle();
         end
         begin
            for (int c = 0; c < 14; c++) begin
               @(negedge clk);
               bus.out_ready = (c >= 6 && c <= 9) ? 1'b0 : 1'b1;
               if (c >= 6 && c <= 9) begin
                  #1;
                  chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                  chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
               end
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three pairs in flight
      send(nom, 1'b0);
      send(nom, 1'b0);
      send(nom, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_out_score", 64'(bus.out_score), 64'd0);
      chk("midrst_out_ok",    64'(bus.out_ok),    64'd0);
      n_push -= exp_q.size();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      chk("no_stale_results", 64'(seen), 64'd0);
      send(nom, 1'b1);
      idle();
      drain();

`ifdef CHAIN_SCORE_BAND_EN
      send(mk(1000, 900, 560, 500, 5000, 64, 32, 32'h8000_0000, 1'b0), 1'b0);
      send(mk(1000, 900, 560, 500, 5000, 64, 40, 32'd48, 1'b1), 1'b0);
      idle();
      drain();
`endif

      repeat (5) @(negedge clk);
      chk("result_count", 64'(n_out), 64'(n_push));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
